// File: rtl/spi_pkg.sv
// Shared SPI definitions for the SPI master and slave endpoints.
package spi_pkg;

  localparam int              SPI_BYTE_W = 8;
  localparam logic [7:0]      SPI_FILLER = 8'h00;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic spi_cpol(input logic [1:0] mode);
    return mode inside {2'd2, 2'd3};
  endfunction

  function automatic logic spi_cpha(input logic [1:0] mode);
    return mode inside {2'd1, 2'd3};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin plus registered rise/fall pulses.
// o_Sync, o_Rise and o_Fall are mutually aligned, one cycle behind the last sync flop.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_Async};
      r_prev <= w_sync;
      r_rise <= w_sync & ~r_prev;
      r_fall <= ~w_sync & r_prev;
    end
  end

  assign o_Sync = r_prev;
  assign o_Rise = r_rise;
  assign o_Fall = r_fall;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/CS_n/MOSI in i_Clk, one byte received and sent per 8 SCLKs.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) while deselected or in reset.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_CS_Active,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO
);

  localparam logic [1:0] MODE  = SPI_MODE[1:0];
  localparam logic       CPOL  = spi_cpol(MODE);
  localparam logic       CPHA  = spi_cpha(MODE);
  localparam int         CNT_W = $clog2(SPI_BYTE_W);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_lead, w_trail, w_en, w_sample, w_change;
  logic w_entry, w_last, w_load, w_mosi;

  spi_state_e              r_state, w_state_nxt;
  logic [SYNC_STAGES:0]    r_mosi_sync;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [SPI_BYTE_W-2:0]   r_rx;
  logic [SPI_BYTE_W-1:0]   r_rx_byte;
  logic                    r_rx_dv;
  logic [SPI_BYTE_W-1:0]   r_tx;
  logic                    r_skip;
  logic [SPI_BYTE_W-1:0]   r_hold;
  logic                    r_hold_vld;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_SPI_Clk),
    .o_Sync  (w_sclk_sync),
    .o_Rise  (w_sclk_rise),
    .o_Fall  (w_sclk_fall)
  );

  // CS chain resets to "selected" so a CS held low across reset release is not taken as a fresh fall.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_SPI_CS_n),
    .o_Sync  (w_cs_sync),
    .o_Rise  (w_cs_rise),
    .o_Fall  (w_cs_fall)
  );

  // One extra MOSI flop keeps data aligned with the registered SCLK edge pulses.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], i_SPI_MOSI};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES];

  assign w_lead   = (w_sclk_rise | w_sclk_fall) & (w_sclk_sync != CPOL);
  assign w_trail  = (w_sclk_rise | w_sclk_fall) & (w_sclk_sync == CPOL);
  assign w_en     = (r_state == ACTIVE) & ~w_cs_sync;
  assign w_sample = w_en & (CPHA ? w_trail : w_lead);
  assign w_change = w_en & (CPHA ? w_lead : w_trail);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_entry     = (r_state == IDLE) & w_cs_fall;
    w_last      = w_sample & (r_bit_cnt == CNT_W'(SPI_BYTE_W - 1));
    w_load      = w_entry | w_last;
    o_CS_Active = (r_state == ACTIVE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bit_cnt  <= '0;
      r_rx       <= '0;
      r_rx_byte  <= '0;
      r_rx_dv    <= 1'b0;
      r_tx       <= SPI_FILLER;
      r_skip     <= 1'b0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;

      if (w_entry || w_cs_rise) r_bit_cnt <= '0;
      else if (w_sample)        r_bit_cnt <= r_bit_cnt + CNT_W'(1);

      if (w_sample) begin
        r_rx <= {r_rx[SPI_BYTE_W-3:0], w_mosi};
        if (w_last) begin
          r_rx_byte <= {r_rx, w_mosi};
          r_rx_dv   <= 1'b1;
        end
      end

      // CPHA=1 never shifts on a byte's first change edge; CPHA=0 only skips the one after a byte-end load.
      if (w_load) begin
        r_tx   <= r_hold_vld ? r_hold : SPI_FILLER;
        r_skip <= CPHA | w_last;
      end else if (w_change) begin
        if (r_skip) r_skip <= 1'b0;
        else        r_tx   <= {r_tx[SPI_BYTE_W-2:0], 1'b0};
      end

      // A load consumes the pre-write holding state; a same-cycle write lands for the next byte.
      if (w_load && r_hold_vld) begin
        r_hold_vld <= 1'b0;
      end else if (i_TX_DV && !r_hold_vld) begin
        r_hold     <= i_TX_Byte;
        r_hold_vld <= 1'b1;
      end
    end
  end

  assign o_TX_Ready = ~r_hold_vld;
  assign o_RX_DV    = r_rx_dv;
  assign o_RX_Byte  = r_rx_byte;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_SPI_MISO = o_CS_Active ? r_tx[SPI_BYTE_W-1] : 1'bz;
`else
  assign o_SPI_MISO = o_CS_Active & r_tx[SPI_BYTE_W-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, master model per mode, RX/MISO scoreboards.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 4;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      sclk, cs_n, tx_dv, tx_ready, rx_dv, cs_act, miso;
  logic [3:0][7:0] tx_byte, rx_byte;
  logic            mosi;

  int         n_pass = 0;
  int         n_chk  = 0;
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] mexp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2)) u_dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_TX_Byte   (tx_byte[g]),
      .i_TX_DV     (tx_dv[g]),
      .o_TX_Ready  (tx_ready[g]),
      .o_RX_DV     (rx_dv[g]),
      .o_RX_Byte   (rx_byte[g]),
      .o_CS_Active (cs_act[g]),
      .i_SPI_Clk   (sclk[g]),
      .i_SPI_CS_n  (cs_n[g]),
      .i_SPI_MOSI  (mosi),
      .o_SPI_MISO  (miso[g])
    );
  end

  // Every cycle o_RX_DV is high logs one event, so a stretched pulse shows up as an extra byte.
  always @(negedge clk)
    for (int m = 0; m < 4; m++)
      if (rx_dv[m]) obs_q.push_back({m[1:0], rx_byte[m]});

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input int m, input logic [7:0] b);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    wait_clk(1);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_fall(input int m);
    cs_n[m] = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_rise(input int m);
    wait_clk(HALF);
    cs_n[m] = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic cpha, cpol;
    cpha = m[0];
    cpol = m[1];
    rx   = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi    = tx[7-i];
        wait_clk(HALF);
        sclk[m] = ~cpol;
        rx      = {rx[6:0], miso[m]};
        wait_clk(HALF);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi    = tx[7-i];
        wait_clk(HALF);
        sclk[m] = cpol;
        rx      = {rx[6:0], miso[m]};
        wait_clk(HALF);
      end
    end
  endtask

  task automatic test_reset;
    for (int m = 0; m < 4; m++) begin
      n_chk++; if (rx_dv[m] !== 1'b0) $display("FAIL reset_rx_dv m%0d: got %b expected 0", m, rx_dv[m]); else n_pass++;
      n_chk++; if (rx_byte[m] !== 8'h00) $display("FAIL reset_rx_byte m%0d: got %h expected 00", m, rx_byte[m]); else n_pass++;
      n_chk++; if (tx_ready[m] !== 1'b1) $display("FAIL reset_tx_ready m%0d: got %b expected 1", m, tx_ready[m]); else n_pass++;
      n_chk++; if (cs_act[m] !== 1'b0) $display("FAIL reset_cs_active m%0d: got %b expected 0", m, cs_act[m]); else n_pass++;
      n_chk++; if (miso[m] !== MISO_IDLE) $display("FAIL reset_miso m%0d: got %b expected %b", m, miso[m], MISO_IDLE); else n_pass++;
    end
  endtask

  task automatic test_mode0_single;
    logic [7:0] r, me;
    logic [9:0] e, o;
    tx_load(0, 8'hA5);
    exp_q.push_back({2'd0, 8'h3C});
    mexp_q.push_back(8'hA5);
    cs_fall(0);
    n_chk++; if (cs_act[0] !== 1'b1) $display("FAIL single_cs_active: got %b expected 1", cs_act[0]); else n_pass++;
    spi_bits(0, 8'h3C, 8, r);
    cs_rise(0);
    me = mexp_q.pop_front();
    n_chk++; if (r !== me) $display("FAIL single_miso: got %h expected %h", r, me); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL single_rx_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL single_rx_byte: got %h expected %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] r0, r1, me;
    logic [9:0] e, o;
    tx_load(3, 8'h12);
    n_chk++; if (tx_ready[3] !== 1'b0) $display("FAIL b2b_ready_low: got %b expected 0", tx_ready[3]); else n_pass++;
    exp_q.push_back({2'd3, 8'h81}); exp_q.push_back({2'd3, 8'h7E});
    mexp_q.push_back(8'h12);        mexp_q.push_back(8'h34);
    cs_fall(3);
    fork
      begin
        spi_bits(3, 8'h81, 8, r0);
        spi_bits(3, 8'h7E, 8, r1);
      end
      begin
        int k;
        k = 0;
        while (tx_ready[3] !== 1'b1 && k < 50) begin wait_clk(1); k++; end
        n_chk++; if (k >= 50) $display("FAIL b2b_ready_timeout: got ready %b expected 1", tx_ready[3]); else n_pass++;
        tx_load(3, 8'h34);
      end
    join
    cs_rise(3);
    me = mexp_q.pop_front();
    n_chk++; if (r0 !== me) $display("FAIL b2b_miso0: got %h expected %h", r0, me); else n_pass++;
    me = mexp_q.pop_front();
    n_chk++; if (r1 !== me) $display("FAIL b2b_miso1: got %h expected %h", r1, me); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_rx_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL b2b_rx_byte: got %h expected %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_underrun;
    logic [7:0] r, me;
    logic [9:0] e, o;
    for (int m = 1; m <= 2; m++) begin
      exp_q.push_back({m[1:0], 8'hF0});
      mexp_q.push_back(8'h00);
      cs_fall(m);
      spi_bits(m, 8'hF0, 8, r);
      cs_rise(m);
      me = mexp_q.pop_front();
      n_chk++; if (r !== me) $display("FAIL underrun_miso m%0d: got %h expected %h", m, r, me); else n_pass++;
      n_chk++; if (tx_ready[m] !== 1'b1) $display("FAIL underrun_ready m%0d: got %b expected 1", m, tx_ready[m]); else n_pass++;
      n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL underrun_rx_count m%0d: got %0d expected %0d", m, obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_chk++; if (o !== e) $display("FAIL underrun_rx_byte m%0d: got %h expected %h", m, o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_cs_abort;
    logic [7:0] r, me;
    logic [9:0] e, o;
    cs_fall(0);
    spi_bits(0, 8'hFF, 5, r);
    cs_rise(0);
    n_chk++; if (cs_act[0] !== 1'b0) $display("FAIL abort_cs_active: got %b expected 0", cs_act[0]); else n_pass++;
    n_chk++; if (miso[0] !== MISO_IDLE) $display("FAIL abort_miso_idle: got %b expected %b", miso[0], MISO_IDLE); else n_pass++;
    n_chk++; if (obs_q.size() != 0) $display("FAIL abort_no_dv: got %0d pulses expected 0", obs_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.push_back({2'd0, 8'hC3});
    mexp_q.push_back(8'h00);
    cs_fall(0);
    spi_bits(0, 8'hC3, 8, r);
    cs_rise(0);
    me = mexp_q.pop_front();
    n_chk++; if (r !== me) $display("FAIL abort_next_miso: got %h expected %h", r, me); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL abort_rx_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL abort_rx_byte: got %h expected %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ignored_load;
    logic [7:0] r0, r1, me;
    logic [9:0] e, o;
    tx_load(0, 8'hAA);
    tx_load(0, 8'h55);
    n_chk++; if (tx_ready[0] !== 1'b0) $display("FAIL ignored_ready: got %b expected 0", tx_ready[0]); else n_pass++;
    exp_q.push_back({2'd0, 8'h96});
    mexp_q.push_back(8'hAA);
    cs_fall(0);
    spi_bits(0, 8'h96, 8, r0);
    cs_rise(0);
    me = mexp_q.pop_front();
    n_chk++; if (r0 !== me) $display("FAIL ignored_miso: got %h expected %h", r0, me); else n_pass++;
    // i_TX_DV lands on the same cycle as the CS-entry load.
    exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd0, 8'h22});
    mexp_q.push_back(8'h00);        mexp_q.push_back(8'h99);
    cs_n[0] = 1'b0;
    wait_clk(3);
    n_chk++; if (cs_act[0] !== 1'b0) $display("FAIL simul_pre_cs: got %b expected 0", cs_act[0]); else n_pass++;
    tx_load(0, 8'h99);
    n_chk++; if (cs_act[0] !== 1'b1) $display("FAIL simul_cs_latency: got %b expected 1", cs_act[0]); else n_pass++;
    n_chk++; if (tx_ready[0] !== 1'b0) $display("FAIL simul_ready: got %b expected 0", tx_ready[0]); else n_pass++;
    wait_clk(2);
    spi_bits(0, 8'h11, 8, r0);
    spi_bits(0, 8'h22, 8, r1);
    cs_rise(0);
    me = mexp_q.pop_front();
    n_chk++; if (r0 !== me) $display("FAIL simul_miso0: got %h expected %h", r0, me); else n_pass++;
    me = mexp_q.pop_front();
    n_chk++; if (r1 !== me) $display("FAIL simul_miso1: got %h expected %h", r1, me); else n_pass++;
    n_chk++; if (tx_ready[0] !== 1'b1) $display("FAIL simul_ready_back: got %b expected 1", tx_ready[0]); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL ignored_rx_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL ignored_rx_byte: got %h expected %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0] r, me;
    logic [9:0] e, o;
    tx_load(0, 8'hFF);
    cs_fall(0);
    tx_load(0, 8'h77);
    spi_bits(0, 8'hA0, 4, r);
    n_chk++; if (miso[0] !== 1'b1) $display("FAIL midbyte_miso: got %b expected 1", miso[0]); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (rx_byte[0] !== 8'h00) $display("FAIL rst_mid_rx_byte: got %h expected 00", rx_byte[0]); else n_pass++;
    n_chk++; if (rx_dv[0] !== 1'b0) $display("FAIL rst_mid_rx_dv: got %b expected 0", rx_dv[0]); else n_pass++;
    n_chk++; if (tx_ready[0] !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", tx_ready[0]); else n_pass++;
    n_chk++; if (cs_act[0] !== 1'b0) $display("FAIL rst_mid_cs_active: got %b expected 0", cs_act[0]); else n_pass++;
    n_chk++; if (miso[0] !== MISO_IDLE) $display("FAIL rst_mid_miso: got %b expected %b", miso[0], MISO_IDLE); else n_pass++;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    spi_bits(0, 8'hFF, 8, r);
    n_chk++; if (cs_act[0] !== 1'b0) $display("FAIL rst_no_restart_cs: got %b expected 0", cs_act[0]); else n_pass++;
    n_chk++; if (obs_q.size() != 0) $display("FAIL rst_no_restart_dv: got %0d pulses expected 0", obs_q.size()); else n_pass++;
    obs_q.delete();
    cs_n[0] = 1'b1;
    wait_clk(8);
    exp_q.push_back({2'd0, 8'h5A});
    mexp_q.push_back(8'h00);
    cs_fall(0);
    spi_bits(0, 8'h5A, 8, r);
    cs_rise(0);
    me = mexp_q.pop_front();
    n_chk++; if (r !== me) $display("FAIL rst_fresh_miso: got %h expected %h", r, me); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL rst_fresh_rx_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL rst_fresh_rx_byte: got %h expected %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    sclk    = 4'b1100;
    cs_n    = 4'hF;
    tx_dv   = '0;
    tx_byte = '0;
    mosi    = 1'b0;
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(3);
    test_reset();
    rst_n = 1'b1;
    wait_clk(6);
    test_mode0_single();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_ignored_load();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
